// File: rtl/demux_1_4_stream_if.sv
// Stream bundle for the 1:4 demultiplexer: one input channel with a 2-bit
// destination select, and four output valid/ready pairs sharing one data bus.
interface demux_1_4_stream_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_1_4_stream.sv
// 1:4 stream demultiplexer with a main + skid elastic buffer; strict in-order
// delivery, the head word's select picks the single active out_valid bit.
module demux_1_4_stream #(
  parameter int W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_1_4_stream_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd3
  } state_t;

  state_t       state, state_nxt;
  logic [W-1:0] main_data, skid_data;
  logic [1:0]   main_sel, skid_sel;
  logic         in_ready_q;
  logic         main_valid;
  logic         accept, drain;
  logic         load_main_in, load_main_skid, load_skid;

  assign main_valid = (state != EMPTY);
  assign accept     = bus.in_valid && in_ready_q;
  // Only the head word's destination ready can drain it.
  assign drain      = main_valid && bus.out_ready[main_sel];

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
      main_sel  <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= bus.in_data;
        main_sel  <= bus.in_sel;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_sel  <= skid_sel;
      end
      if (load_skid) begin
        skid_data <= bus.in_data;
        skid_sel  <= bus.in_sel;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = main_data;
  assign bus.out_valid = main_valid ? (4'b0001 << main_sel) : 4'b0000;

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Scoreboard bench for demux_1_4_stream: accepted words are queued in order and
// a monitor pops one per output transfer, checking data, destination and hold.
module tb_demux_1_4_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_deliv = 0;
  logic [5:0] exp_q[$];

  demux_1_4_stream_if #(.W(4)) bus ();

  demux_1_4_stream #(.W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drives one word and holds it until the handshake completes.
  task automatic send(input logic [3:0] d, input logic [1:0] s);
    int  t = 0;
    bit  ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sel   = s;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (bus.in_ready && rst_n) begin
        exp_q.push_back({s, d});
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      t++;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL send_timeout: word %0h sel %0d never accepted", d, s);
    end
  endtask

  // Monitor: one-hot, hold-while-stalled, and in-order scoreboard.
  logic       prev_pending = 1'b0;
  logic [3:0] prev_valid = '0;
  logic [3:0] prev_data = '0;

  always @(negedge clk) begin
    logic       xfer;
    logic [5:0] item;
    int         idx;
    if (!rst_n) begin
      prev_pending = 1'b0;
    end else begin
      if (prev_pending) begin
        chk("hold_valid", bus.out_valid, prev_valid);
        chk("hold_data", bus.out_data, prev_data);
      end
      if (bus.out_valid != 4'b0000)
        chk("onehot", $countones(bus.out_valid), 1);
      xfer = |(bus.out_valid & bus.out_ready);
      if (xfer) begin
        idx = 0;
        for (int k = 0; k < 4; k++) if (bus.out_valid[k]) idx = k;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_out: got data %0h sel %0d, expected nothing", bus.out_data, idx);
        end else begin
          item = exp_q.pop_front();
          chk("deliver_word", {idx[1:0], bus.out_data}, item);
          n_deliv++;
        end
      end
      prev_pending = (bus.out_valid != 4'b0000) && !xfer;
      prev_valid   = bus.out_valid;
      prev_data    = bus.out_data;
    end
  end

  logic [3:0] sw_data[4] = '{4'hA, 4'hB, 4'hC, 4'hD};
  bit         rnd_done;
  int         c0, d0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = '0;
    bus.out_ready = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_valid", bus.out_valid, 4'b0000);
    chk("rst_hold_ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 4'b0000);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_data", bus.out_data, 4'h0);

    // Routing sweep, one word per cycle, 1-cycle latency.
    bus.out_ready = 4'b1111;
    fork
      for (int i = 0; i < 4; i++) send(sw_data[i], 2'(i));
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        #1;
        chk("sweep_valid", bus.out_valid, 4'b0001 << i);
        chk("sweep_data", bus.out_data, sw_data[i]);
        chk("sweep_ready", bus.in_ready, 1'b1);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Backpressure into the skid.
    bus.out_ready = 4'b0000;
    fork
      begin
        send(4'h5, 2'd2);
        send(4'h6, 2'd1);
        send(4'h7, 2'd0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        chk("bp_in_ready_low", bus.in_ready, 1'b0);
        chk("bp_valid", bus.out_valid, 4'b0100);
        chk("bp_data", bus.out_data, 4'h5);
        repeat (3) begin
          @(posedge clk);
          #1;
          chk("bp_stall_valid", bus.out_valid, 4'b0100);
          chk("bp_stall_ready", bus.in_ready, 1'b0);
        end
        bus.out_ready = 4'b0100;
        @(posedge clk);
        #1;
        chk("bp_skid_valid", bus.out_valid, 4'b0010);
        chk("bp_skid_data", bus.out_data, 4'h6);
        chk("bp_ready_back", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("bp_refill_valid", bus.out_valid, 4'b0010);
        chk("bp_refill_ready", bus.in_ready, 1'b0);
        bus.out_ready = 4'b0010;
        @(posedge clk);
        #1;
        chk("bp_last_valid", bus.out_valid, 4'b0001);
        chk("bp_last_data", bus.out_data, 4'h7);
        bus.out_ready = 4'b1111;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Head-of-line blocking on destination 3.
    bus.out_ready = 4'b0111;
    send(4'h9, 2'd3);
    send(4'h1, 2'd0);
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("hol_valid", bus.out_valid, 4'b1000);
      chk("hol_data", bus.out_data, 4'h9);
    end
    bus.out_ready = 4'b1111;
    repeat (3) @(posedge clk);
    #1;

    // Sustained throughput: 256 random words, all ready.
    c0 = cyc;
    d0 = n_deliv;
    for (int i = 0; i < 256; i++) send(4'($urandom), 2'($urandom));
    chk("tput_cycles", cyc - c0, 256);
    repeat (2) @(posedge clk);
    #1;
    chk("tput_delivered", n_deliv - d0, 256);

    // Random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) send(4'($urandom), 2'($urandom));
        rnd_done = 1'b1;
      end
      while (!rnd_done) begin
        @(posedge clk);
        #1;
        bus.out_ready = 4'($urandom);
      end
    join
    bus.out_ready = 4'b1111;
    repeat (4) @(posedge clk);
    #1;
    chk("rnd_drained", exp_q.size(), 0);

    // Reset while FULL.
    bus.out_ready = 4'b0000;
    send(4'h3, 2'd1);
    send(4'h4, 2'd2);
    chk("full_ready_low", bus.in_ready, 1'b0);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_valid", bus.out_valid, 4'b0000);
    chk("async_rst_ready", bus.in_ready, 1'b1);
    chk("async_rst_data", bus.out_data, 4'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 4'b1111;
    send(4'h8, 2'd2);
    chk("post_rst_valid", bus.out_valid, 4'b0100);
    chk("post_rst_data", bus.out_data, 4'h8);
    repeat (3) @(posedge clk);
    #1;
    chk("final_empty", exp_q.size(), 0);
    chk("final_idle", bus.out_valid, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
